cal_sequencer: RTL and testbench

Calibration controller for the fixed-point level-interpolation datapath. It steps the operator through `NUM_POINTS` calibration points and averages `2**AVG_LOG2` filtered sensor samples per point. It writes each averaged count into the calibration-point table, then computes each segment's reciprocal `2**RECIP_SHIFT / ΔN` with an iterative divider and writes it into the reciprocal table. It sits beside the measurement FSM and owns both tables while `cal_busy` is high.

---
 rtl/cal_pkg.sv | 27 ++
 rtl/recip_div.sv | 92 +++++++++
 rtl/cal_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_cal_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cal_pkg
// Description : Shared types and constants for the calibration sequencer:
//               state encoding, parameter defaults, quotient saturation value.
// Revision    : 1.0 - initial release
// ============================================================================
package cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_STORE  = 3'd3,
    ST_DIV    = 3'd4,
    ST_RSTORE = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } cal_state_t;

  localparam int          c_num_points_def  = 4;
  localparam int          c_avg_log2_def    = 2;
  localparam int          c_recip_shift_def = 24;
  localparam logic [15:0] c_sat_quot        = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/recip_div.sv
`default_nettype none
// ============================================================================
// Module      : recip_div
// Description : Sequential restoring divider computing 2**RECIP_SHIFT / divisor,
//               one quotient bit per cycle (RECIP_SHIFT+1 cycles after start).
//               The 16-bit quotient output saturates to 16'hFFFF.
//               Only instantiated when CAL_RECIP_EN is defined.
//               RECIP_SHIFT must be at least 16.
// Revision    : 1.0 - initial release
// ============================================================================
module recip_div
  import cal_pkg::*;
#(
  parameter int RECIP_SHIFT = c_recip_shift_def
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot
);

  localparam int QW = RECIP_SHIFT + 1;
  localparam int CW = $clog2(RECIP_SHIFT + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   dvs_q, dvs_d;
  logic [QW-1:0] q_q, q_d;

  logic [16:0]   w_trial;
  logic          w_fits;

  // The dividend is a single one at bit RECIP_SHIFT, so the next dividend bit
  // is 1 only while the counter still points at the top bit.
  assign w_trial = {rem_q, (cnt_q == CW'(RECIP_SHIFT))};
  assign w_fits  = (w_trial >= {1'b0, dvs_q});

  // Next-state: load on start, then shift/subtract one bit per cycle.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    q_d    = q_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(RECIP_SHIFT);
      rem_d  = '0;
      dvs_d  = divisor;
      q_d    = '0;
    end else if (busy_q) begin
      rem_d = w_fits ? 16'(w_trial - {1'b0, dvs_q}) : w_trial[15:0];
      q_d   = {q_q[QW-2:0], w_fits};
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      q_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      q_q    <= q_d;
    end
  end

  // done marks the cycle whose clock edge retires the last quotient bit.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign quot = (q_q > QW'(c_sat_quot)) ? c_sat_quot : q_q[15:0];

endmodule
`default_nettype wire

// File: rtl/cal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cal_sequencer
// Description : Calibration controller. Averages 2**AVG_LOG2 samples per point,
//               writes the point table, checks monotonicity and (with
//               CAL_RECIP_EN defined) writes per-segment reciprocals
//               2**RECIP_SHIFT / dN into the reciprocal table.
//               Build option: CAL_RECIP_EN (undefined = no divider, r_* tied 0).
// Revision    : 1.0 - initial release
// ============================================================================
module cal_sequencer
  import cal_pkg::*;
#(
  parameter int NUM_POINTS  = c_num_points_def,
  parameter int AVG_LOG2    = c_avg_log2_def,
  parameter int RECIP_SHIFT = c_recip_shift_def
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cal_start,
  input  logic        cal_capture,
  input  logic        cal_abort,
  input  logic        filter_valid,
  input  logic [15:0] filter_data,
  output logic        n_we,
  output logic [1:0]  n_addr,
  output logic [15:0] n_data,
  output logic        r_we,
  output logic [1:0]  r_addr,
  output logic [15:0] r_data,
  output logic [1:0]  point_idx,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_err,
  output logic        beep
);

  localparam int         AW         = 16 + AVG_LOG2;
  localparam int         CW         = AVG_LOG2 + 1;
  localparam logic [1:0] c_last_k   = 2'(NUM_POINTS - 1);
  localparam logic [CW-1:0] c_last_s = CW'((2 ** AVG_LOG2) - 1);

  cal_state_t    state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   nprev_q, nprev_d;
  logic          n_we_q, n_we_d;
  logic [1:0]    n_addr_q, n_addr_d;
  logic [15:0]   n_data_q, n_data_d;
  logic          beep_q, beep_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [15:0]   w_mean;
  logic          w_to_div;

  assign w_mean = 16'(acc_q >> AVG_LOG2);

`ifdef CAL_RECIP_EN
  logic          r_we_q, r_we_d;
  logic [1:0]    r_addr_q, r_addr_d;
  logic [15:0]   r_data_q, r_data_d;
  logic          w_div_start, w_div_busy, w_div_done;
  logic [15:0]   w_div_quot;

  // A stored point beyond the first closes a segment that needs a reciprocal.
  assign w_to_div = (k_q != 2'd0);

  recip_div #(
    .RECIP_SHIFT (RECIP_SHIFT)
  ) u_recip_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_div_start),
    .abort   (cal_abort),
    .divisor (w_mean - nprev_q),
    .busy    (w_div_busy),
    .done    (w_div_done),
    .quot    (w_div_quot)
  );
`else
  assign w_to_div = 1'b0;
`endif

  // Next-state and registered-output decode; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nprev_d  = nprev_q;
    n_we_d   = 1'b0;
    n_addr_d = n_addr_q;
    n_data_d = n_data_q;
    beep_d   = 1'b0;
    done_d   = 1'b0;
`ifdef CAL_RECIP_EN
    r_we_d      = 1'b0;
    r_addr_d    = r_addr_q;
    r_data_d    = r_data_q;
    w_div_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (cal_start) begin
          k_d     = 2'd0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cal_capture) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (filter_valid) begin
          acc_d = acc_q + AW'(filter_data);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == c_last_s) begin
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        if ((k_q != 2'd0) && (w_mean <= nprev_q)) begin
          state_d = ST_ERR;
        end else begin
          n_we_d   = 1'b1;
          n_addr_d = k_q;
          n_data_d = w_mean;
          beep_d   = 1'b1;
          nprev_d  = w_mean;
          if (w_to_div) begin
`ifdef CAL_RECIP_EN
            w_div_start = 1'b1;
`endif
            state_d = ST_DIV;
          end else if (k_q == c_last_k) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_ARM;
          end
        end
      end
`ifdef CAL_RECIP_EN
      ST_DIV: begin
        if (w_div_done) begin
          state_d = ST_RSTORE;
        end else if (!w_div_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_RSTORE: begin
        r_we_d   = 1'b1;
        r_addr_d = k_q - 2'd1;
        r_data_d = w_div_quot;
        if (k_q == c_last_k) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = ST_ARM;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (cal_abort) begin
      state_d = ST_IDLE;
      n_we_d  = 1'b0;
      beep_d  = 1'b0;
      done_d  = 1'b0;
`ifdef CAL_RECIP_EN
      r_we_d      = 1'b0;
      w_div_start = 1'b0;
`endif
    end

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
    err_d  = (state_d == ST_ERR);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      nprev_q  <= '0;
      n_we_q   <= 1'b0;
      n_addr_q <= '0;
      n_data_q <= '0;
      beep_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CAL_RECIP_EN
      r_we_q   <= 1'b0;
      r_addr_q <= '0;
      r_data_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nprev_q  <= nprev_d;
      n_we_q   <= n_we_d;
      n_addr_q <= n_addr_d;
      n_data_q <= n_data_d;
      beep_q   <= beep_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef CAL_RECIP_EN
      r_we_q   <= r_we_d;
      r_addr_q <= r_addr_d;
      r_data_q <= r_data_d;
`endif
    end
  end

  assign n_we      = n_we_q;
  assign n_addr    = n_addr_q;
  assign n_data    = n_data_q;
  assign point_idx = k_q;
  assign cal_busy  = busy_q;
  assign cal_done  = done_q;
  assign cal_err   = err_q;
  assign beep      = beep_q;
`ifdef CAL_RECIP_EN
  assign r_we      = r_we_q;
  assign r_addr    = r_addr_q;
  assign r_data    = r_data_q;
`else
  assign r_we      = 1'b0;
  assign r_addr    = 2'd0;
  assign r_data    = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cal_sequencer
// Description : Directed, table-driven bench for cal_sequencer with hand-
//               computed point/reciprocal values, plus corner-case sequences
//               (averaging, abort, busy start, reset during division).
//               Expectations follow the CAL_RECIP_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cal_sequencer;

`ifdef CAL_RECIP_EN
  localparam bit RECIP = 1'b1;
`else
  localparam bit RECIP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0][15:0] pts;
    logic [2:0][15:0] exp_r;
    int               exp_n;
    int               exp_rn;
    logic             exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cal_start = 1'b0, cal_capture = 1'b0, cal_abort = 1'b0;
  logic        filter_valid = 1'b0;
  logic [15:0] filter_data = 16'd0;
  logic        n_we, r_we, cal_busy, cal_done, cal_err, beep;
  logic [1:0]  n_addr, r_addr, point_idx;
  logic [15:0] n_data, r_data;

  cal_sequencer #(
    .NUM_POINTS  (4),
    .AVG_LOG2    (2),
    .RECIP_SHIFT (24)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cal_start    (cal_start),
    .cal_capture  (cal_capture),
    .cal_abort    (cal_abort),
    .filter_valid (filter_valid),
    .filter_data  (filter_data),
    .n_we         (n_we),
    .n_addr       (n_addr),
    .n_data       (n_data),
    .r_we         (r_we),
    .r_addr       (r_addr),
    .r_data       (r_data),
    .point_idx    (point_idx),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .cal_err      (cal_err),
    .beep         (beep)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Strobe monitor: logs every table write and counts pulses.
  logic [1:0]  n_addr_log[$];
  logic [15:0] n_data_log[$];
  logic [1:0]  r_addr_log[$];
  logic [15:0] r_data_log[$];
  int done_cnt = 0, beep_cnt = 0;
  int nwe_cyc = 0, rwe_cyc = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (n_we) begin
      n_addr_log.push_back(n_addr);
      n_data_log.push_back(n_data);
      nwe_cyc = cyc;
    end
    if (r_we) begin
      r_addr_log.push_back(r_addr);
      r_data_log.push_back(r_data);
      rwe_cyc = cyc;
    end
    if (cal_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (beep) beep_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for strobe", name);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({n_we, n_addr, n_data, r_we, r_addr, r_data,
                point_idx, cal_busy, cal_done, cal_err, beep});
  endfunction

  function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int en, input int r0, input int r1, input int r2,
                              input int rn, input logic err);
    vec_t v;
    v.pts[0] = 16'(p0); v.pts[1] = 16'(p1); v.pts[2] = 16'(p2); v.pts[3] = 16'(p3);
    v.exp_r[0] = 16'(r0); v.exp_r[1] = 16'(r1); v.exp_r[2] = 16'(r2);
    v.exp_n = en;
    v.exp_rn = rn;
    v.exp_err = err;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    cal_start = 1'b1; tick(1); cal_start = 1'b0;
  endtask

  task automatic pulse_abort();
    cal_abort = 1'b1; tick(1); cal_abort = 1'b0;
  endtask

  task automatic feed_point(input logic [15:0] v);
    cal_capture = 1'b1; tick(1); cal_capture = 1'b0;
    for (int s = 0; s < 4; s++) begin
      filter_valid = 1'b1; filter_data = v; tick(1);
    end
    filter_valid = 1'b0;
  endtask

  task automatic wait_nwe_or_err(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (n_we || cal_err) begin ok = 1'b1; break; end
      tick(1);
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic wait_rwe(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (r_we) begin ok = 1'b1; break; end
      tick(1);
    end
    if (!ok) timeout_fail(name);
  endtask

  vec_t vecs[5];

  initial begin
    int nb, rb, db, bb, exp_rn, c0, c1;

    // {points}, n writes, {reciprocals}, r writes, error expected
    vecs[0] = mk(521, 27335, 39867, 52174, 4, 625, 1338, 1363, 3, 1'b0);
    vecs[1] = mk(1000, 1200, 40000, 60000, 4, 16'hFFFF, 432, 838, 3, 1'b0);
    vecs[2] = mk(521, 500, 0, 0, 1, 0, 0, 0, 0, 1'b1);
    vecs[3] = mk(100, 200, 200, 0, 2, 16'hFFFF, 0, 0, 1, 1'b1);
    vecs[4] = mk(0, 1, 2, 65535, 4, 16'hFFFF, 16'hFFFF, 256, 3, 1'b0);

    // Reset state
    tick(2);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_outputs", all_outs(), 64'd0);

    // Table-driven full runs
    for (int r = 0; r < 5; r++) begin
      pulse_abort();
      nb = n_data_log.size(); rb = r_data_log.size();
      db = done_cnt; bb = beep_cnt;
      pulse_start();
      for (int p = 0; p < 4; p++) begin
        feed_point(vecs[r].pts[p]);
        wait_nwe_or_err($sformatf("row%0d_p%0d_store", r, p));
        if (cal_err) break;
        if (RECIP && p > 0) wait_rwe($sformatf("row%0d_p%0d_recip", r, p));
      end
      tick(3);
      exp_rn = RECIP ? vecs[r].exp_rn : 0;
      check($sformatf("row%0d_n_count", r), 64'(n_data_log.size() - nb), 64'(vecs[r].exp_n));
      for (int i = 0; i < vecs[r].exp_n; i++) begin
        check($sformatf("row%0d_n_addr%0d", r, i),
              (nb + i < n_data_log.size()) ? 64'(n_addr_log[nb + i]) : 64'hBAD, 64'(i));
        check($sformatf("row%0d_n_data%0d", r, i),
              (nb + i < n_data_log.size()) ? 64'(n_data_log[nb + i]) : 64'hBAD, 64'(vecs[r].pts[i]));
      end
      check($sformatf("row%0d_r_count", r), 64'(r_data_log.size() - rb), 64'(exp_rn));
      for (int i = 0; i < exp_rn; i++) begin
        check($sformatf("row%0d_r_addr%0d", r, i),
              (rb + i < r_data_log.size()) ? 64'(r_addr_log[rb + i]) : 64'hBAD, 64'(i));
        check($sformatf("row%0d_r_data%0d", r, i),
              (rb + i < r_data_log.size()) ? 64'(r_data_log[rb + i]) : 64'hBAD, 64'(vecs[r].exp_r[i]));
      end
      check($sformatf("row%0d_err", r), 64'(cal_err), 64'(vecs[r].exp_err));
      check($sformatf("row%0d_done_pulses", r), 64'(done_cnt - db), vecs[r].exp_err ? 64'd0 : 64'd1);
      check($sformatf("row%0d_beeps", r), 64'(beep_cnt - bb), 64'(vecs[r].exp_n));
      check($sformatf("row%0d_busy", r), 64'(cal_busy), 64'd0);
      if (r == 0) begin
`ifdef CAL_RECIP_EN
        check("nwe_to_rwe_cycles", 64'(rwe_cyc - nwe_cyc), 64'd26);
        check("done_with_last_rwe", 64'(done_cyc), 64'(rwe_cyc));
`else
        check("done_with_last_nwe", 64'(done_cyc), 64'(nwe_cyc));
`endif
      end
      if (vecs[r].exp_err) begin
        pulse_start();
        check($sformatf("row%0d_err_cleared", r), 64'({cal_err, cal_busy, point_idx}), 64'b0_1_00);
      end
    end

    // Averaging: valid during ARM and in the capture cycle is ignored
    pulse_abort();
    pulse_start();
    filter_valid = 1'b1; filter_data = 16'd60000; tick(2);
    c0 = cyc;
    cal_capture = 1'b1; tick(1); cal_capture = 0;
    for (int s = 0; s < 4; s++) begin
      filter_data = 16'(100 + s); tick(1);
    end
    filter_valid = 1'b0;
    wait_nwe_or_err("avg_store");
    c1 = cyc;
    check("avg_n_data", 64'(n_data), 64'd101);
    check("avg_n_addr", 64'(n_addr), 64'd0);
    check("capture_to_nwe_cycles", 64'(c1 - (c0 + 1)), 64'd5);
    check("avg_point_idx", 64'(point_idx), 64'd1);
    tick(1);
    check("nwe_one_cycle", 64'({n_we, beep}), 64'd0);

    // Start while busy is ignored; abort mid-ACCUM at point 2
    pulse_start();
    check("busy_start_ignored", 64'({cal_busy, point_idx}), 64'b1_01);
    feed_point(16'd200);
    wait_nwe_or_err("abort_p1_store");
    if (RECIP) wait_rwe("abort_p1_recip");
    tick(1);
    cal_capture = 1'b1; tick(1); cal_capture = 1'b0;
    filter_valid = 1'b1; filter_data = 16'd300; tick(2);
    nb = n_data_log.size(); rb = r_data_log.size();
    cal_abort = 1'b1; tick(1); cal_abort = 1'b0;
    check("abort_state", 64'({cal_busy, cal_err, n_we, r_we}), 64'd0);
    cal_capture = 1'b1; tick(4); cal_capture = 1'b0;
    filter_valid = 1'b0;
    tick(40);
    check("abort_no_writes", 64'({n_data_log.size() - nb, r_data_log.size() - rb}), 64'd0);
    check("abort_idle", 64'(cal_busy), 64'd0);

    // Reset while dividing segment 0
    pulse_start();
    feed_point(16'd1000);
    wait_nwe_or_err("rst_p0_store");
    tick(1);
    feed_point(16'd2000);
    wait_nwe_or_err("rst_p1_store");
    rb = r_data_log.size();
    tick(5);
    rst_n = 1'b0;
    #1;
    check("reset_mid_div_outputs", all_outs(), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("reset_mid_div_no_rwe", 64'(r_data_log.size() - rb), 64'd0);
    check("reset_mid_div_idle", all_outs(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
